// File: rtl/pulse_bank_pkg.sv
// Shared APU definitions for the pulse voices: register layout, length and duty tables.
package pulse_bank_pkg;

  typedef struct packed {
    logic [1:0] duty;
    logic       halt;
    logic       const_vol;
    logic [3:0] vol;
    logic [7:0] r1;
    logic [7:0] timer_lo;
    logic [4:0] length_idx;
    logic [2:0] timer_hi;
  } pulse_regs_t;

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  // Leftmost bit of each pattern is sequencer step 0.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] idx);
    logic [7:0] pattern;
    pattern = DUTY_TABLE[duty];
    return pattern[3'd7 - idx];
  endfunction

endpackage

// File: rtl/pulse_voice.sv
// One pulse voice: period timer, duty sequencer, envelope and length counter.
module pulse_voice
  import pulse_bank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        apu_clk_en,
  input  logic        quarter_clk_en,
  input  logic        half_clk_en,
  input  logic [1:0]  duty,
  input  logic        halt,
  input  logic        const_vol,
  input  logic [3:0]  vol,
  input  logic [10:0] period,
  input  logic        r3_wr,
  input  logic [4:0]  load_idx,
  input  logic        enabled,
  output logic [3:0]  voice_out,
  output logic        length_nz
);

  logic [10:0] timer;
  logic [2:0]  seq_idx;
  logic [7:0]  length;
  logic        env_start;
  logic [3:0]  decay;
  logic [3:0]  divider;
  logic [3:0]  volume;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timer   <= '0;
      seq_idx <= '0;
    end else begin
      if (apu_clk_en) begin
        if (timer == 11'd0) begin
          timer   <= period;
          seq_idx <= seq_idx - 3'd1;
        end else begin
          timer <= timer - 11'd1;
        end
      end
      if (r3_wr) seq_idx <= 3'd0;
    end
  end

  // `enabled` is the post-write enable, so a disable clears the counter on the same edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      length <= '0;
    end else if (r3_wr && enabled) begin
      length <= LENGTH_TABLE[load_idx];
    end else if (!enabled) begin
      length <= '0;
    end else if (half_clk_en && length != 8'd0 && !halt) begin
      length <= length - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      env_start <= 1'b0;
      decay     <= '0;
      divider   <= '0;
    end else begin
      if (quarter_clk_en) begin
        if (env_start) begin
          env_start <= 1'b0;
          decay     <= 4'd15;
          divider   <= vol;
        end else if (divider == 4'd0) begin
          divider <= vol;
          if (decay != 4'd0)  decay <= decay - 4'd1;
          else if (halt)      decay <= 4'd15;
        end else begin
          divider <= divider - 4'd1;
        end
      end
      if (r3_wr) env_start <= 1'b1;
    end
  end

  assign length_nz = |length;
  assign volume    = const_vol ? vol : decay;
  // Periods below 8 are ultrasonic and muted.
  assign voice_out = (duty_bit(duty, seq_idx) && length_nz && |period[10:3]) ? volume : 4'd0;

endmodule

// File: rtl/pulse_bank.sv
// Bank of NUM_CH pulse voices with register decode, ENABLE/status register and mixer.
module pulse_bank
  import pulse_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             cpu_clk_en,
  input  logic                             apu_clk_en,
  input  logic                             quarter_clk_en,
  input  logic                             half_clk_en,
  input  logic [ADDR_W-1:0]                reg_addr,
  input  logic [7:0]                       reg_data_in,
  input  logic                             reg_en,
  input  logic                             reg_we,
  output logic [7:0]                       reg_data_out,
  output logic [NUM_CH-1:0]                length_non_zero,
  output logic [4+$clog2(NUM_CH+1)-1:0]    mix_out
);

  localparam int MIX_W = 4 + $clog2(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] ENABLE_ADDR = ADDR_W'(4 * NUM_CH);

  logic                    wr_en;
  logic                    rd_en;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       enable_nxt;
  logic [NUM_CH-1:0][3:0]  voice_out;
  logic [MIX_W-1:0]        mix_sum;

  assign wr_en      = reg_en & reg_we & cpu_clk_en;
  assign rd_en      = reg_en & ~reg_we & cpu_clk_en;
  assign enable_nxt = (wr_en && reg_addr == ENABLE_ADDR) ? reg_data_in[NUM_CH-1:0] : enable;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) enable <= '0;
    else        enable <= enable_nxt;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_voice
    pulse_regs_t regs;
    logic        sel;
    logic        r3_wr;

    // Upper address bits select the voice; addresses at or above ENABLE never match.
    assign sel   = wr_en && (reg_addr[ADDR_W-1:2] == (ADDR_W-2)'(c));
    assign r3_wr = sel && (reg_addr[1:0] == 2'd3);

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        regs <= '0;
      end else if (sel) begin
        case (reg_addr[1:0])
          2'd0:    {regs.duty, regs.halt, regs.const_vol, regs.vol} <= reg_data_in;
          2'd1:    regs.r1 <= reg_data_in;
          2'd2:    regs.timer_lo <= reg_data_in;
          default: {regs.length_idx, regs.timer_hi} <= reg_data_in;
        endcase
      end
    end

    pulse_voice u_voice (
      .clk            (clk),
      .rst_l          (rst_l),
      .apu_clk_en     (apu_clk_en),
      .quarter_clk_en (quarter_clk_en),
      .half_clk_en    (half_clk_en),
      .duty           (regs.duty),
      .halt           (regs.halt),
      .const_vol      (regs.const_vol),
      .vol            (regs.vol),
      .period         ({regs.timer_hi, regs.timer_lo}),
      .r3_wr          (r3_wr),
      .load_idx       (reg_data_in[7:3]),
      .enabled        (enable_nxt[c]),
      .voice_out      (voice_out[c]),
      .length_nz      (length_non_zero[c])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) mix_sum = mix_sum + MIX_W'(voice_out[c]);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mix_out      <= '0;
      reg_data_out <= '0;
    end else begin
      mix_out <= mix_sum;
      if (rd_en) reg_data_out <= (reg_addr == ENABLE_ADDR) ? 8'(length_non_zero) : 8'd0;
    end
  end

endmodule

// File: tb/tb_pulse_bank.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model of pulse_bank.
module tb_pulse_bank;

  localparam int NCH     = 4;
  localparam int AW      = 6;
  localparam int EN_ADDR = 4 * NCH;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          cpu_clk_en, apu_clk_en, quarter_clk_en, half_clk_en;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_data_in;
  logic          reg_en, reg_we;
  logic [7:0]    reg_data_out;
  logic [NCH-1:0] length_non_zero;
  logic [6:0]    mix_out;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_bank #(.NUM_CH(NCH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en), .apu_clk_en(apu_clk_en),
    .quarter_clk_en(quarter_clk_en), .half_clk_en(half_clk_en),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_en(reg_en), .reg_we(reg_we),
    .reg_data_out(reg_data_out), .length_non_zero(length_non_zero), .mix_out(mix_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  string duty_pat [4] = '{"01000000", "01100000", "01111000", "10011111"};

  int m_timer[NCH], m_seq[NCH], m_len[NCH], m_start[NCH], m_decay[NCH], m_div[NCH];
  int m_duty[NCH], m_halt[NCH], m_const[NCH], m_vol[NCH], m_period[NCH];
  int m_en, m_mix, m_rdata;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_timer[c] = 0; m_seq[c] = 0; m_len[c] = 0; m_start[c] = 0; m_decay[c] = 0;
      m_div[c] = 0; m_duty[c] = 0; m_halt[c] = 0; m_const[c] = 0; m_vol[c] = 0;
      m_period[c] = 0;
    end
    m_en = 0; m_mix = 0; m_rdata = 0;
  endfunction

  function automatic int model_lnz();
    int v = 0;
    for (int c = 0; c < NCH; c++) if (m_len[c] != 0) v += (1 << c);
    return v;
  endfunction

  function automatic int voice_level(int c);
    int level = (m_const[c] != 0) ? m_vol[c] : m_decay[c];
    if (duty_pat[m_duty[c]].getc(m_seq[c]) != "1") return 0;
    if (m_len[c] == 0 || m_period[c] < 8) return 0;
    return level;
  endfunction

  // One clock edge of the block, all decisions taken from pre-edge state.
  function automatic void model_step();
    int  sum = 0;
    int  a   = int'(reg_addr);
    int  d   = int'(reg_data_in);
    bit  wr  = cpu_clk_en && reg_en && reg_we;
    int  en_new = m_en;
    for (int c = 0; c < NCH; c++) sum += voice_level(c);
    if (cpu_clk_en && reg_en && !reg_we) m_rdata = (a == EN_ADDR) ? model_lnz() : 0;
    if (wr && a == EN_ADDR) en_new = d % (1 << NCH);
    for (int c = 0; c < NCH; c++) begin
      bit r3 = wr && (a == 4 * c + 3);
      bit on = ((en_new >> c) & 1) != 0;
      if (apu_clk_en) begin
        if (m_timer[c] == 0) begin m_timer[c] = m_period[c]; m_seq[c] = (m_seq[c] + 7) % 8; end
        else m_timer[c]--;
      end
      if (r3) m_seq[c] = 0;
      if (r3 && on) m_len[c] = len_tab[d / 8];
      else if (!on) m_len[c] = 0;
      else if (half_clk_en && m_len[c] > 0 && m_halt[c] == 0) m_len[c]--;
      if (quarter_clk_en) begin
        if (m_start[c] != 0) begin m_start[c] = 0; m_decay[c] = 15; m_div[c] = m_vol[c]; end
        else if (m_div[c] == 0) begin
          m_div[c] = m_vol[c];
          if (m_decay[c] > 0) m_decay[c]--;
          else if (m_halt[c] != 0) m_decay[c] = 15;
        end else m_div[c]--;
      end
      if (r3) m_start[c] = 1;
    end
    m_en = en_new;
    if (wr && a < EN_ADDR) begin
      int c = a / 4;
      case (a % 4)
        0: begin m_duty[c] = d / 64; m_halt[c] = (d / 32) % 2; m_const[c] = (d / 16) % 2; m_vol[c] = d % 16; end
        2: m_period[c] = (m_period[c] / 256) * 256 + d;
        3: m_period[c] = (d % 8) * 256 + (m_period[c] % 256);
        default: ;
      endcase
    end
    m_mix = sum;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    if (rst_l) model_step(); else model_reset();
    #1;
    check("mix_out", 32'(mix_out), 32'(m_mix));
    check("length_non_zero", 32'(length_non_zero), 32'(model_lnz()));
    check("reg_data_out", 32'(reg_data_out), 32'(m_rdata));
  endtask

  task automatic write_reg(input int a, input int d, input bit with_half = 1'b0);
    reg_addr = AW'(a); reg_data_in = 8'(d); reg_en = 1'b1; reg_we = 1'b1;
    half_clk_en = with_half;
    cycle();
    reg_en = 1'b0; reg_we = 1'b0; half_clk_en = 1'b0;
  endtask

  task automatic read_reg(input int a);
    reg_addr = AW'(a); reg_en = 1'b1; reg_we = 1'b0;
    cycle();
    reg_en = 1'b0;
  endtask

  task automatic run(input int n, input bit apu);
    apu_clk_en = apu;
    repeat (n) cycle();
    apu_clk_en = 1'b0;
  endtask

  task automatic pulse_half();
    half_clk_en = 1'b1; cycle(); half_clk_en = 1'b0;
  endtask

  task automatic pulse_quarter();
    quarter_clk_en = 1'b1; cycle(); quarter_clk_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int high_cnt;
    model_reset();
    rst_l = 1'b0; cpu_clk_en = 1'b1; apu_clk_en = 1'b0; quarter_clk_en = 1'b0;
    half_clk_en = 1'b0; reg_addr = '0; reg_data_in = '0; reg_en = 1'b0; reg_we = 1'b0;
    repeat (3) cycle();
    rst_l = 1'b1;
    check("reset_mix", 32'(mix_out), 0);
    check("reset_lnz", 32'(length_non_zero), 0);
    check("reset_rdata", 32'(reg_data_out), 0);

    // Scenario 1: duty 2 at period 8, constant volume 15.
    write_reg(EN_ADDR, 8'h01);
    write_reg(0, 8'hBF);
    write_reg(2, 8'h08);
    write_reg(3, 8'h08);
    run(8, 1'b1);
    high_cnt = 0;
    apu_clk_en = 1'b1;
    for (int i = 0; i < 72; i++) begin
      cycle();
      if (mix_out == 7'd15) high_cnt++;
    end
    apu_clk_en = 1'b0;
    check("s1_duty_high_cycles", 32'(high_cnt), 36);

    // Scenario 2: length 254 runs out after exactly 254 half-frame strobes.
    write_reg(0, 8'h9F);
    write_reg(3, 8'h08);
    repeat (253) pulse_half();
    check("s2_len_253", 32'(length_non_zero[0]), 1);
    pulse_half();
    check("s2_len_254", 32'(length_non_zero[0]), 0);
    read_reg(EN_ADDR);
    check("s2_enable_read", 32'(reg_data_out), 32'h00);

    // Scenario 3: length load wins over a coincident half-frame decrement.
    write_reg(3, 8'h00, 1'b1);
    repeat (9) pulse_half();
    check("s3_len_after_9", 32'(length_non_zero[0]), 1);
    pulse_half();
    check("s3_len_after_10", 32'(length_non_zero[0]), 0);

    // Scenario 4: looping decay envelope with divider period 0.
    write_reg(0, 8'hE0);
    write_reg(3, 8'h08);
    for (int i = 0; i < 17; i++) begin
      pulse_quarter();
      cycle();
      check("s4_decay", 32'(mix_out), (i < 16) ? 32'(15 - i) : 32'd15);
    end

    // Scenario 5: period 7 is muted, period 8 in phase sums to 60.
    write_reg(EN_ADDR, 8'h0F);
    for (int v = 0; v < NCH; v++) begin
      write_reg(4 * v, 8'hFF); write_reg(4 * v + 2, 8'h07); write_reg(4 * v + 3, 8'h08);
    end
    cycle();
    check("s5_period7_mix", 32'(mix_out), 0);
    run(20, 1'b1);
    check("s5_period7_run", 32'(mix_out), 0);
    for (int v = 0; v < NCH; v++) begin
      write_reg(4 * v + 2, 8'h08); write_reg(4 * v + 3, 8'h08);
    end
    cycle();
    check("s5_period8_peak", 32'(mix_out), 60);
    run(40, 1'b1);

    // Scenario 6: disabling clears lengths; reset mid-note silences everything.
    write_reg(EN_ADDR, 8'h00);
    check("s6_disable_lnz", 32'(length_non_zero), 0);
    write_reg(EN_ADDR, 8'h0F);
    for (int v = 0; v < NCH; v++) write_reg(4 * v + 3, 8'h08);
    cycle();
    check("s6_sounding", 32'(mix_out), 60);
    read_reg(EN_ADDR);
    check("s6_status_read", 32'(reg_data_out), 32'h0F);
    #2 rst_l = 1'b0;
    #1;
    check("s6_async_mix", 32'(mix_out), 0);
    check("s6_async_lnz", 32'(length_non_zero), 0);
    check("s6_async_rdata", 32'(reg_data_out), 0);
    model_reset();
    cycle();
    rst_l = 1'b1;
    write_reg(EN_ADDR, 8'h0F);
    run(30, 1'b1);
    check("s6_silent_no_r3", 32'(mix_out), 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int a;
      int d;
      apu_clk_en     = 1'($urandom_range(0, 1));
      quarter_clk_en = ($urandom_range(0, 7) == 0);
      half_clk_en    = ($urandom_range(0, 7) == 0);
      cpu_clk_en     = ($urandom_range(0, 3) != 0);
      reg_en         = ($urandom_range(0, 4) == 0);
      reg_we         = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 19));
      d = int'($urandom_range(0, 255));
      if (a < EN_ADDR && a % 4 == 3 && $urandom_range(0, 3) != 0) d = d - (d % 8);
      if (a == EN_ADDR && $urandom_range(0, 3) != 0) d = 8'h0F;
      reg_addr = AW'(a);
      reg_data_in = 8'(d);
      cycle();
    end
    cpu_clk_en = 1'b1; reg_en = 1'b0; reg_we = 1'b0;
    apu_clk_en = 1'b0; quarter_clk_en = 1'b0; half_clk_en = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_bank.md
PULSE_BANK -- requirements
Module: pulse_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of pulse voices (legal 1..8).
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the register address width (2^ADDR_W > 4*NUM_CH).
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port rst_l, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have ports cpu_clk_en and apu_clk_en, input, 1 each, the CPU-rate and APU-rate clock enables.
REQ-006 The block SHALL have ports quarter_clk_en and half_clk_en, input, 1 each, the frame-sequencer strobes.
REQ-007 The block SHALL have ports reg_addr (input, ADDR_W), reg_data_in (input, 8), reg_en (input, 1) and reg_we (input, 1), forming the register access port.
REQ-008 The block SHALL have port reg_data_out, output, 8, the registered status read data.
REQ-009 The block SHALL have port length_non_zero, output, NUM_CH, where bit c is 1 when voice c's length counter is not zero.
REQ-010 The block SHALL have port mix_out, output, 4+$clog2(NUM_CH+1), the linear sum of all voice outputs.

Function
REQ-011 A register write SHALL take effect only on a cycle where reg_en, reg_we and cpu_clk_en are all 1.
REQ-012 Voice c SHALL own addresses 4c..4c+3, with these register fields:
- R0: duty[7:6], halt[5], const_vol[4], vol[3:0].
- R1: stored, no function.
- R2: timer_lo[7:0].
- R3: length_idx[7:3], timer_hi[2:0].
REQ-013 Address 4*NUM_CH SHALL be ENABLE: a write stores bit c as enable for voice c, and a read returns {zero-padded, length_non_zero}.
REQ-014 Writes to unmapped addresses SHALL be ignored, and reads of any address other than ENABLE SHALL return 0.
REQ-015 reg_data_out SHALL update only on cpu_clk_en, from the read decode, when reg_en=1 and reg_we=0.
REQ-016 Each voice SHALL have an 11-bit timer that decrements on apu_clk_en; at 0 it reloads {timer_hi,timer_lo} and steps the 3-bit sequencer (index decrements, wraps 0->7).
REQ-017 The sequencer bit SHALL be taken from the duty table:
- duty 0: 01000000.
- duty 1: 01100000.
- duty 2: 01111000.
- duty 3: 10011111.
REQ-018 A write to R3 SHALL reset the sequencer to 0, set the envelope start flag, and, if the voice is enabled, load the length counter from LENGTH_TABLE[length_idx].
REQ-019 On half_clk_en, the length counter SHALL decrement when it is nonzero and halt=0.
REQ-020 An R3 length load coinciding with half_clk_en SHALL take priority, so the loaded value is kept without a decrement.
REQ-021 Clearing an enable bit SHALL zero that voice's length counter in the same cycle, and R3 loads to a disabled voice SHALL not load the length counter.
REQ-022 On quarter_clk_en, the envelope SHALL act as follows:
- If the start flag is set: clear it, set decay=15, divider=vol.
- Otherwise, when divider=0: reload divider=vol and decrement decay if nonzero; if decay=0 and halt=1, decay wraps to 15.
- Otherwise: decrement divider.
REQ-023 Voice volume SHALL be vol when const_vol=1, and decay otherwise.
REQ-024 Voice output SHALL be 0 when the sequencer bit is 0, the length counter is 0, or the timer period is < 8; otherwise it SHALL be the voice volume.
REQ-025 mix_out SHALL be the unsigned sum of all voice outputs, registered on clk, with a maximum of 15*NUM_CH and no overflow possible.

Reset
REQ-026 On rst_l=0, the following SHALL clear to 0 asynchronously: all register fields, enables, timers, sequencers, length counters, envelope state, reg_data_out, length_non_zero and mix_out.
REQ-027 A reset asserted mid-note SHALL silence mix_out immediately and require a new R3 write before any voice sounds again.

Structure
REQ-028 LENGTH_TABLE (32x8, standard NES values), DUTY_TABLE (4x8) and the pulse register field typedef SHALL live in the shared APU package.
REQ-029 The block SHALL contain one sub-module, pulse_voice (timer, sequencer, envelope, length counter), instantiated NUM_CH times by generate; address decode, ENABLE, status read and the mixer stay in pulse_bank.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Scenario 1: NUM_CH=4; enable=0x1; voice 0 gets R0=0xBF (duty 2, halt, const 15), R2=0x08, R3=0x08 -> mix_out toggles between 0 and 15 with a 4/8 duty, one sequencer step every 9 apu_clk_en.
- Scenario 2: R3 length_idx=1 (254) with halt=0 -> length_non_zero[0] falls to 0 after exactly 254 half_clk_en; ENABLE read returns 0x00.
- Scenario 3: a half_clk_en in the same cycle as an R3 write with length_idx=0 -> length counter equals 10, not 9.
- Scenario 4: const_vol=0, vol=0, halt=1, then 17 quarter_clk_en -> voice volume follows 15,14,...,0,15 (wrap).
- Scenario 5: all 4 voices sounding at const 15 and timer period 7 -> mix_out=0; at period 8 in phase -> mix_out peaks at 60.
- Scenario 6: writing ENABLE=0x0 while lengths are nonzero -> length_non_zero=0 the next cycle; rst_l pulsed mid-note -> mix_out=0 and all outputs zero asynchronously.
